// File: rtl/goertzel_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | goertzel_pkg                                                           |
// | Shared widths, defaults and finalizer state type for goertzel_detector |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
package goertzel_pkg;

    localparam int FRAC_BITS = 16;
    localparam int COEFF_W   = 18;
    localparam int PWR_W     = 64;
    localparam int CNT_W     = 16;
    localparam int ACC_W_DEF = 48;
    localparam int N_DEF     = 260;
    localparam logic signed [COEFF_W-1:0] COEFF_DEF = 18'sd106039;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SQ    = 2'd1,
        ST_CROSS = 2'd2,
        ST_OUT   = 2'd3
    } fin_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/goertzel_power.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | goertzel_power                                                         |
// | Block-end snapshot, power finalizer FSM, clamp / shift / 64b saturate. |
// | Optional GOERTZEL_SAT_EN: carries the recurrence saturation flag.      |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module goertzel_power
    import goertzel_pkg::*;
#(
    parameter int                         ACC_W     = ACC_W_DEF,
    parameter logic signed [COEFF_W-1:0]  COEFF     = COEFF_DEF,
    parameter int                         PWR_SHIFT = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    snap_en,
    input  logic signed [ACC_W-1:0] snap_s1,
    input  logic signed [ACC_W-1:0] snap_s2,
`ifdef GOERTZEL_SAT_EN
    input  logic                    snap_sat,
    output logic                    sat_flag,
`endif
    output logic                    ready,
    output logic [PWR_W-1:0]        power
);

    localparam int P_W = max_int(2*ACC_W + 4, PWR_W + 2);
    localparam int X_W = max_int(2*ACC_W + COEFF_W + 2, P_W);

    fin_state_t              state_q, state_d;
    logic                    pend_q, pend_d;
    logic signed [ACC_W-1:0] hold_s1_q, hold_s1_d, hold_s2_q, hold_s2_d;
    logic signed [P_W-1:0]   acc_q, acc_d;
    logic [PWR_W-1:0]        power_q, power_d;
    logic                    ready_q, ready_d;

    logic signed [P_W-1:0]   w_s1_p, w_s2_p, w_sq1, w_sq2, w_cross_p;
    logic signed [X_W-1:0]   w_s1_x, w_s2_x, w_coeff_x, w_cross;
    logic [P_W-1:0]          w_clamp, w_shift;
    logic [PWR_W-1:0]        w_pwr;

    assign w_s1_p    = {{(P_W-ACC_W){hold_s1_q[ACC_W-1]}}, hold_s1_q};
    assign w_s2_p    = {{(P_W-ACC_W){hold_s2_q[ACC_W-1]}}, hold_s2_q};
    assign w_s1_x    = {{(X_W-ACC_W){hold_s1_q[ACC_W-1]}}, hold_s1_q};
    assign w_s2_x    = {{(X_W-ACC_W){hold_s2_q[ACC_W-1]}}, hold_s2_q};
    assign w_coeff_x = {{(X_W-COEFF_W){COEFF[COEFF_W-1]}}, COEFF};

    assign w_sq1     = w_s1_p * w_s1_p;
    assign w_sq2     = w_s2_p * w_s2_p;
    assign w_cross   = w_coeff_x * w_s1_x * w_s2_x;
    assign w_cross_p = P_W'(w_cross >>> FRAC_BITS);

    // Negative power is a rounding artefact of the Q2.16 cross term.
    assign w_clamp = acc_q[P_W-1] ? '0 : acc_q;
    assign w_shift = w_clamp >> PWR_SHIFT;
    assign w_pwr   = (|(w_shift >> PWR_W)) ? '1 : PWR_W'(w_shift);

`ifdef GOERTZEL_SAT_EN
    logic hold_sat_q, hold_sat_d, sat_flag_q, sat_flag_d;
`endif

    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        hold_s1_d = hold_s1_q;
        hold_s2_d = hold_s2_q;
        acc_d     = acc_q;
        power_d   = power_q;
        ready_d   = 1'b0;
`ifdef GOERTZEL_SAT_EN
        hold_sat_d = hold_sat_q;
        sat_flag_d = sat_flag_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pend_q) begin
                    pend_d  = 1'b0;
                    state_d = ST_SQ;
                end
            end
            ST_SQ: begin
                acc_d   = w_sq1;
                state_d = ST_CROSS;
            end
            ST_CROSS: begin
                acc_d   = acc_q + w_sq2 - w_cross_p;
                state_d = ST_OUT;
            end
            ST_OUT: begin
                power_d = w_pwr;
                ready_d = 1'b1;
`ifdef GOERTZEL_SAT_EN
                sat_flag_d = hold_sat_q;
`endif
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (snap_en) begin
            hold_s1_d = snap_s1;
            hold_s2_d = snap_s2;
            pend_d    = 1'b1;
`ifdef GOERTZEL_SAT_EN
            hold_sat_d = snap_sat;
`endif
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            pend_q    <= 1'b0;
            hold_s1_q <= '0;
            hold_s2_q <= '0;
            acc_q     <= '0;
            power_q   <= '0;
            ready_q   <= 1'b0;
`ifdef GOERTZEL_SAT_EN
            hold_sat_q <= 1'b0;
            sat_flag_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pend_q    <= pend_d;
            hold_s1_q <= hold_s1_d;
            hold_s2_q <= hold_s2_d;
            acc_q     <= acc_d;
            power_q   <= power_d;
            ready_q   <= ready_d;
`ifdef GOERTZEL_SAT_EN
            hold_sat_q <= hold_sat_d;
            sat_flag_q <= sat_flag_d;
`endif
        end
    end

    assign ready = ready_q;
    assign power = power_q;
`ifdef GOERTZEL_SAT_EN
    assign sat_flag = sat_flag_q;
`endif

endmodule
`default_nettype wire

// File: rtl/goertzel_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | goertzel_detector                                                      |
// | Single-bin Goertzel recurrence over N-sample blocks, bin power output. |
// | Optional GOERTZEL_SAT_EN: saturating recurrence plus sat_flag output.  |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module goertzel_detector
    import goertzel_pkg::*;
#(
    parameter int                         N         = N_DEF,
    parameter logic signed [COEFF_W-1:0]  COEFF     = COEFF_DEF,
    parameter int                         ACC_W     = ACC_W_DEF,
    parameter int                         PWR_SHIFT = 0
) (
    input  logic               clock,
    input  logic               reset,
    input  logic signed [31:0] sample,
    input  logic               sample_valid,
`ifdef GOERTZEL_SAT_EN
    output logic               sat_flag,
`endif
    output logic               ready,
    output logic [PWR_W-1:0]   power
);

    localparam int              MUL_W    = ACC_W + COEFF_W;
    localparam int              SUM_W    = MUL_W + 2;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N - 1);

    if (N < 8 || N > 65535) begin : g_illegal_n
        $error("goertzel_detector: N=%0d outside legal range 8..65535", N);
    end

    logic signed [ACC_W-1:0] s1_q, s1_d, s2_q, s2_d;
    logic [CNT_W-1:0]        count_q, count_d;
    logic                    w_blk_end;

    logic signed [MUL_W-1:0] w_coeff_x, w_s1_x, w_prod, w_fb;
    logic signed [SUM_W-1:0] w_smp_x, w_fb_x, w_s2_x, w_sum;
    logic signed [ACC_W-1:0] w_s0;

    assign w_coeff_x = {{(MUL_W-COEFF_W){COEFF[COEFF_W-1]}}, COEFF};
    assign w_s1_x    = {{(MUL_W-ACC_W){s1_q[ACC_W-1]}}, s1_q};
    assign w_prod    = w_coeff_x * w_s1_x;
    assign w_fb      = w_prod >>> FRAC_BITS;

    assign w_smp_x = {{(SUM_W-32){sample[31]}}, sample};
    assign w_fb_x  = {{2{w_fb[MUL_W-1]}}, w_fb};
    assign w_s2_x  = {{(SUM_W-ACC_W){s2_q[ACC_W-1]}}, s2_q};
    assign w_sum   = w_smp_x + w_fb_x - w_s2_x;

`ifdef GOERTZEL_SAT_EN
    logic w_ovf;
    logic sat_acc_q, sat_acc_d;

    assign w_ovf = (w_sum[SUM_W-1:ACC_W-1] != {(SUM_W-ACC_W+1){w_sum[SUM_W-1]}});
    assign w_s0  = !w_ovf          ? ACC_W'(w_sum) :
                   w_sum[SUM_W-1]  ? {1'b1, {(ACC_W-1){1'b0}}} :
                                     {1'b0, {(ACC_W-1){1'b1}}};
`else
    assign w_s0 = ACC_W'(w_sum);
`endif

    // The accepting edge of sample N both snapshots and restarts the block.
    always_comb begin
        s1_d      = s1_q;
        s2_d      = s2_q;
        count_d   = count_q;
        w_blk_end = 1'b0;
`ifdef GOERTZEL_SAT_EN
        sat_acc_d = sat_acc_q;
`endif
        if (sample_valid) begin
`ifdef GOERTZEL_SAT_EN
            sat_acc_d = sat_acc_q | w_ovf;
`endif
            if (count_q == LAST_CNT) begin
                s1_d      = '0;
                s2_d      = '0;
                count_d   = '0;
                w_blk_end = 1'b1;
`ifdef GOERTZEL_SAT_EN
                sat_acc_d = 1'b0;
`endif
            end else begin
                s1_d    = w_s0;
                s2_d    = s1_q;
                count_d = count_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            s1_q    <= '0;
            s2_q    <= '0;
            count_q <= '0;
`ifdef GOERTZEL_SAT_EN
            sat_acc_q <= 1'b0;
`endif
        end else begin
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            count_q <= count_d;
`ifdef GOERTZEL_SAT_EN
            sat_acc_q <= sat_acc_d;
`endif
        end
    end

    goertzel_power #(
        .ACC_W     (ACC_W),
        .COEFF     (COEFF),
        .PWR_SHIFT (PWR_SHIFT)
    ) u_power (
        .clock    (clock),
        .reset    (reset),
        .snap_en  (w_blk_end),
        .snap_s1  (w_s0),
        .snap_s2  (s1_q),
`ifdef GOERTZEL_SAT_EN
        .snap_sat (sat_acc_q | w_ovf),
        .sat_flag (sat_flag),
`endif
        .ready    (ready),
        .power    (power)
    );

endmodule
`default_nettype wire

// File: tb/tb_goertzel_detector.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | tb_goertzel_detector                                                   |
// | Randomised block stimulus against a wide-integer Goertzel model.       |
// | Rev 1.0 - initial release                                              |
// +------------------------------------------------------------------------+
module tb_goertzel_detector;

    localparam int                 c_N         = 260;
    localparam logic signed [17:0] c_COEFF     = 18'sd106039;
    localparam int                 c_ACC_W     = 48;
    localparam int                 c_PWR_SHIFT = 0;
    localparam int                 c_W         = 160;
    localparam real                c_PI        = 3.14159265358979;

    logic               clock = 1'b0;
    logic               reset;
    logic signed [31:0] sample;
    logic               sample_valid;
    logic               ready;
    logic [63:0]        power;
`ifdef GOERTZEL_SAT_EN
    logic               sat_flag;
`endif

    int          n_chk  = 0;
    int          n_fail = 0;
    int unsigned cyc    = 0;
    int          blk[c_N];

    int unsigned rdy_cyc[$];
    logic [63:0] rdy_pwr[$];
    logic        rdy_sat[$];
    int unsigned exp_cyc[$];
    logic [63:0] exp_pwr[$];
    logic        exp_sat[$];
    logic [63:0] last_pwr;
    logic [63:0] onbin_pwr;

    goertzel_detector #(
        .N         (c_N),
        .COEFF     (c_COEFF),
        .ACC_W     (c_ACC_W),
        .PWR_SHIFT (c_PWR_SHIFT)
    ) u_dut (
        .clock        (clock),
        .reset        (reset),
        .sample       (sample),
        .sample_valid (sample_valid),
`ifdef GOERTZEL_SAT_EN
        .sat_flag     (sat_flag),
`endif
        .ready        (ready),
        .power        (power)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    always @(negedge clock) begin
        if (ready) begin
            rdy_cyc.push_back(cyc);
            rdy_pwr.push_back(power);
`ifdef GOERTZEL_SAT_EN
            rdy_sat.push_back(sat_flag);
`else
            rdy_sat.push_back(1'b0);
`endif
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void gen_block(input int kind, input real amp);
        for (int n = 0; n < c_N; n++) begin
            case (kind)
                0:       blk[n] = 0;
                1:       blk[n] = int'(amp * $sin(2.0 * c_PI * 26.0 * n / c_N));
                2:       blk[n] = int'(amp * $sin(2.0 * c_PI * 13.0 * n / c_N));
                3:       blk[n] = 100;
                4:       blk[n] = int'($urandom_range(0, 2000)) - 1000;
                default: blk[n] = int'($urandom);
            endcase
        end
    endfunction

    // Direct evaluation of the recurrence and power formula in 160-bit integers.
    function automatic logic [63:0] model_power(output logic satf);
        logic signed [c_W-1:0] s0, s1, s2, t, p, lim, cf;
        cf   = c_COEFF;
        s1   = '0;
        s2   = '0;
        satf = 1'b0;
        lim  = 1;
        lim  = lim <<< (c_ACC_W - 1);
        for (int n = 0; n < c_N; n++) begin
            s0 = blk[n];
            t  = cf * s1;
            s0 = s0 + (t >>> 16) - s2;
`ifdef GOERTZEL_SAT_EN
            if (s0 >= lim) begin
                s0 = lim - 1;
                satf = 1'b1;
            end else if (s0 < -lim) begin
                s0 = -lim;
                satf = 1'b1;
            end
`else
            t  = s0 <<< (c_W - c_ACC_W);
            s0 = t >>> (c_W - c_ACC_W);
`endif
            s2 = s1;
            s1 = s0;
        end
        p = s1 * s1 + s2 * s2 - ((cf * s1 * s2) >>> 16);
        if (p < 0) p = 0;
        p = p >>> c_PWR_SHIFT;
        if ((p >>> 64) != 0) return '1;
        return p[63:0];
    endfunction

    // gap > 0: fixed strobe period; gap <= 0: random period 1..4.
    task automatic drive_samples(input int cnt, input int gap, output int unsigned acc_cyc);
        int idle;
        acc_cyc = 0;
        for (int n = 0; n < cnt; n++) begin
            @(negedge clock);
            sample       = blk[n];
            sample_valid = 1'b1;
            acc_cyc      = cyc + 1;
            idle = (gap > 0) ? gap - 1 : int'($urandom_range(0, 3));
            for (int g = 0; g < idle; g++) begin
                @(negedge clock);
                sample_valid = 1'b0;
                sample       = $urandom;
            end
        end
        @(negedge clock);
        sample_valid = 1'b0;
    endtask

    task automatic stream(input int nblk, input int kind, input real amp, input int gap);
        logic        s;
        int unsigned acc;
        for (int b = 0; b < nblk; b++) begin
            gen_block(kind, amp);
            exp_pwr.push_back(model_power(s));
            exp_sat.push_back(s);
            drive_samples(c_N, gap, acc);
            exp_cyc.push_back(acc + 4);
        end
    endtask

    task automatic settle_and_check(input string tag);
        int n;
        repeat (8) @(negedge clock);
        chk({tag, "_pulses"}, 64'(rdy_cyc.size()), 64'(exp_cyc.size()));
        n = (rdy_cyc.size() < exp_cyc.size()) ? rdy_cyc.size() : exp_cyc.size();
        for (int i = 0; i < n; i++) begin
            chk({tag, "_latency"}, 64'(rdy_cyc[i]), 64'(exp_cyc[i]));
            chk({tag, "_power"}, rdy_pwr[i], exp_pwr[i]);
`ifdef GOERTZEL_SAT_EN
            chk({tag, "_sat"}, 64'(rdy_sat[i]), 64'(exp_sat[i]));
`endif
        end
        last_pwr = power;
        rdy_cyc.delete(); rdy_pwr.delete(); rdy_sat.delete();
        exp_cyc.delete(); exp_pwr.delete(); exp_sat.delete();
    endtask

    task automatic async_reset(input string tag);
        @(posedge clock);
        #3 reset = 1'b1;
        #1;
        chk({tag, "_ready_now"}, 64'(ready), 64'd0);
        chk({tag, "_power_now"}, power, 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            sample_valid = 1'b1;
            sample       = $urandom;
        end
        @(negedge clock);
        sample_valid = 1'b0;
        reset        = 1'b0;
    endtask

    initial begin
        int unsigned acc;
        real         r;
        reset        = 1'b1;
        sample       = '0;
        sample_valid = 1'b0;
        repeat (2) @(negedge clock);
        chk("reset_ready", 64'(ready), 64'd0);
        chk("reset_power", power, 64'd0);

        // Strobes while reset is held must not count.
        for (int i = 0; i < 2 * c_N; i++) begin
            @(negedge clock);
            sample_valid = 1'b1;
            sample       = (i % 2 == 0) ? 32'sd0 : $urandom;
        end
        @(negedge clock);
        sample_valid = 1'b0;
        chk("reset_hold_pulses", 64'(rdy_cyc.size()), 64'd0);
        chk("reset_hold_power", power, 64'd0);
        reset = 1'b0;
        repeat (2) @(negedge clock);

        stream(1, 0, 0.0, 1);
        settle_and_check("zero");

        stream(2, 1, 1000.0, 1);
        settle_and_check("onbin_b2b");
        onbin_pwr = last_pwr;
        r = real'(onbin_pwr);
        chk("onbin_within_1pct", 64'(r > 1.69e10 * 0.99 && r < 1.69e10 * 1.01), 64'd1);

        stream(1, 1, 1000.0, 100);
        settle_and_check("onbin_gap100");
        chk("onbin_gap100_same", last_pwr, onbin_pwr);

        stream(1, 1, 1000.0, 0);
        settle_and_check("onbin_randgap");
        chk("onbin_randgap_same", last_pwr, onbin_pwr);

        stream(1, 2, 1000.0, 1);
        settle_and_check("k13");
        chk("k13_rejected", 64'(last_pwr < 64'd169000000), 64'd1);

        stream(1, 3, 0.0, 1);
        settle_and_check("dc100");
        chk("dc100_rejected", 64'(last_pwr < 64'd10000), 64'd1);

        stream(2, 4, 0.0, 0);
        settle_and_check("rand_small");

        stream(2, 5, 0.0, 1);
        settle_and_check("rand_full");

        stream(1, 1, 2147483647.0, 1);
        settle_and_check("fullscale");
        chk("fullscale_saturated", last_pwr, 64'hFFFF_FFFF_FFFF_FFFF);

        async_reset("rst_midclock");
        chk("rst_midclock_pulses", 64'(rdy_cyc.size()), 64'd0);

        // Partial block then reset: the partial data must be discarded.
        gen_block(1, 1000.0);
        drive_samples(100, 1, acc);
        async_reset("rst_midblock");
        stream(1, 1, 1000.0, 1);
        settle_and_check("after_midblock");
        chk("after_midblock_same", last_pwr, onbin_pwr);

        // Full block then reset while the finalizer is busy: result dropped.
        gen_block(1, 1000.0);
        drive_samples(c_N - 1, 1, acc);
        @(negedge clock);
        sample       = blk[c_N-1];
        sample_valid = 1'b1;
        @(negedge clock);
        sample_valid = 1'b0;
        #2 reset = 1'b1;
        #1;
        chk("rst_midfin_power", power, 64'd0);
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (8) @(negedge clock);
        chk("rst_midfin_pulses", 64'(rdy_cyc.size()), 64'd0);
        chk("rst_midfin_power_after", power, 64'd0);

        stream(1, 4, 0.0, 1);
        settle_and_check("post_reset_rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
